clb_param: RTL and testbench

- Parametrised successor to the single-LUT directional CLB. It has W lanes per side (up/down/right/left) and NB basic logic elements (BLEs), each a K-input LUT with an optional flop.
- Configuration loads through a serial, daisy-chainable shadow chain and becomes active only on an explicit commit. Activation is double-buffered.
- Tiles into the simpleFPGA array. The cfg_so_o of one CLB feeds the cfg_din_i of the next.

---
 rtl/clb_pkg.sv | 35 +++
 rtl/clb_ble.sv | 52 +++++
 rtl/clb_param.sv | 161 ++++++++++++++++
 tb/tb_clb_param.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/clb_pkg.sv
// Shared widths, config field offsets and FSM states for the parametrised CLB.
// Pure compile-time helpers; no logic, no latency, no flow control.
package clb_pkg;

    typedef enum logic {UNCFG = 1'b0, RUN = 1'b1} cfg_state_t;

    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic int sel_width(input int w, input int nb);
        return clog2_min1(4 * w + nb);
    endfunction

    function automatic int osel_width(input int nb);
        return clog2_min1(nb + 1);
    endfunction

    function automatic int ble_bits(input int k, input int sel_w);
        return (1 << k) + k * sel_w + 2;
    endfunction

    function automatic int cfg_bits(input int w, input int k, input int nb);
        return nb * ble_bits(k, sel_width(w, nb)) + 4 * w * osel_width(nb);
    endfunction

    function automatic int ble_base(input int b, input int k, input int sel_w);
        return b * ble_bits(k, sel_w);
    endfunction

    function automatic int out_sel_base(input int nb, input int k, input int sel_w);
        return nb * ble_bits(k, sel_w);
    endfunction

endpackage

// File: rtl/clb_ble.sv
// One basic logic element: K pool muxes into a LUT plus an optional flop.
// LUT path is combinational; flop adds one cycle; i_load overrides i_ce, no backpressure.
module clb_ble #(
    parameter int K     = 4,
    parameter int SEL_W = 3,
    parameter int P     = 6
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic [P-1:0]         i_pool,
    input  logic [(2**K)-1:0]    i_lut,
    input  logic [K*SEL_W-1:0]   i_sel,
    input  logic                 i_ff_en,
    input  logic                 i_load,
    input  logic                 i_init,
    input  logic                 i_ce,
    output logic                 o_q,
    output logic                 o_out
);

    logic [K-1:0] w_addr;
    logic         w_lut_out;
    logic         r_q;

    // Pool indices past P match no entry and therefore read 0.
    always_comb begin
        w_addr = '0;
        for (int i = 0; i < K; i++) begin
            for (int p = 0; p < P; p++) begin
                if (i_sel[i*SEL_W +: SEL_W] == SEL_W'(p)) begin
                    w_addr[i] = i_pool[p];
                end
            end
        end
    end

    assign w_lut_out = i_lut[w_addr];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_q <= 1'b0;
        end else if (i_load) begin
            r_q <= i_init;
        end else if (i_ce) begin
            r_q <= w_lut_out;
        end
    end

    assign o_q   = r_q;
    assign o_out = i_ff_en ? r_q : w_lut_out;

endmodule

// File: rtl/clb_param.sv
// Parametrised directional CLB with serial shadow config chain and double-buffered commit.
// Side paths combinational (one cycle through a registered BLE); config chain has no backpressure.
module clb_param
    import clb_pkg::*;
#(
    parameter int W  = 1,
    parameter int K  = 4,
    parameter int NB = 2
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic [W-1:0] up_i,
    input  logic [W-1:0] down_i,
    input  logic [W-1:0] right_i,
    input  logic [W-1:0] left_i,
    output logic [W-1:0] up_o,
    output logic [W-1:0] down_o,
    output logic [W-1:0] right_o,
    output logic [W-1:0] left_o,
    input  logic         ce_i,
    input  logic         cfg_shift_i,
    input  logic         cfg_din_i,
    input  logic         cfg_commit_i,
    output logic         cfg_so_o,
    output logic         cfg_full_o,
    output logic         cfg_valid_o,
    output logic         cfg_err_o
);

    localparam int P        = 4 * W + NB;
    localparam int SEL_W    = sel_width(W, NB);
    localparam int SEL_O    = osel_width(NB);
    localparam int LUT_N    = 2 ** K;
    localparam int CFG_BITS = cfg_bits(W, K, NB);
    localparam int OSB      = out_sel_base(NB, K, SEL_W);
    localparam int CNT_W    = $clog2(CFG_BITS + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CFG_BITS);

    logic [CFG_BITS-1:0] r_shadow;
    logic [CFG_BITS-1:0] r_active;
    logic [CNT_W-1:0]    r_count;
    logic                r_full;
    logic                r_valid;
    logic                r_err;
    cfg_state_t          r_state;
    cfg_state_t          w_state_nxt;
    logic                w_run;
    logic                w_commit_ok;
    logic                w_shift;

    assign w_commit_ok = cfg_commit_i && r_full;
    assign w_shift     = cfg_shift_i && !cfg_commit_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_shadow <= '0;
            r_active <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
            r_valid  <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_err <= cfg_commit_i && !r_full;
            if (w_commit_ok) begin
                r_active <= r_shadow;
                r_count  <= '0;
                r_full   <= 1'b0;
                r_valid  <= 1'b1;
            end else if (w_shift) begin
                r_shadow <= {cfg_din_i, r_shadow[CFG_BITS-1:1]};
                if (r_count != CNT_MAX) begin
                    r_count <= r_count + 1'b1;
                end
                r_full <= (r_count >= CNT_MAX - 1'b1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= UNCFG;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_run       = 1'b0;
        case (r_state)
            UNCFG:   if (w_commit_ok) w_state_nxt = RUN;
            RUN:     w_run = 1'b1;
            default: w_state_nxt = UNCFG;
        endcase
    end

    logic [NB-1:0]  w_q;
    logic [NB-1:0]  w_ble_out;
    logic [NB-1:0]  w_init;
    logic [P-1:0]   w_pool;
    logic [4*W-1:0] w_in_all;
    logic [4*W-1:0] w_out_all;

    // Only registered q values feed back, so the pool can never close a combinational loop.
    assign w_in_all = {left_i, right_i, down_i, up_i};
    assign w_pool   = {w_q, w_in_all};

    for (genvar b = 0; b < NB; b++) begin : g_ble
        localparam int B = ble_base(b, K, SEL_W);

        // A flop restarts from the init bit of the config being committed, not the old one.
        assign w_init[b] = w_commit_ok ? r_shadow[B+LUT_N+K*SEL_W+1]
                                       : r_active[B+LUT_N+K*SEL_W+1];

        clb_ble #(.K(K), .SEL_W(SEL_W), .P(P)) u_ble (
            .i_clk   (clk_i),
            .i_rst   (rst_i),
            .i_pool  (w_pool),
            .i_lut   (r_active[B +: LUT_N]),
            .i_sel   (r_active[B+LUT_N +: K*SEL_W]),
            .i_ff_en (r_active[B+LUT_N+K*SEL_W]),
            .i_load  (w_commit_ok),
            .i_init  (w_init[b]),
            .i_ce    (ce_i && w_run),
            .o_q     (w_q[b]),
            .o_out   (w_ble_out[b])
        );
    end

    // Side index s: 0 up, 1 down, 2 right, 3 left; s^1 is the opposite side.
    logic [SEL_O-1:0] w_osel;
    always_comb begin
        w_out_all = '0;
        w_osel    = '0;
        for (int s = 0; s < 4; s++) begin
            for (int l = 0; l < W; l++) begin
                w_osel = r_active[OSB + (s*W + l)*SEL_O +: SEL_O];
                if (w_run) begin
                    if (w_osel == '0) begin
                        w_out_all[s*W + l] = w_in_all[(s ^ 1)*W + l];
                    end
                    for (int b = 0; b < NB; b++) begin
                        if (w_osel == SEL_O'(b + 1)) begin
                            w_out_all[s*W + l] = w_ble_out[b];
                        end
                    end
                end
            end
        end
    end

    assign up_o        = w_out_all[0*W +: W];
    assign down_o      = w_out_all[1*W +: W];
    assign right_o     = w_out_all[2*W +: W];
    assign left_o      = w_out_all[3*W +: W];
    assign cfg_so_o    = r_shadow[0];
    assign cfg_full_o  = r_full;
    assign cfg_valid_o = r_valid;
    assign cfg_err_o   = r_err;

endmodule

// File: tb/tb_clb_param.sv
// Directed plus randomized bench for clb_param at default parameters against a bit-level reference model.
module tb_clb_param;

    localparam int CFGB = 68;
    localparam int BLEW = 30;
    localparam int SELW = 3;
    localparam int OSB  = 60;
    localparam int K    = 4;
    localparam int NB   = 2;

    logic clk_i = 1'b0;
    logic rst_i = 1'b1;
    logic up_i = 1'b0, down_i = 1'b0, right_i = 1'b0, left_i = 1'b0;
    logic up_o, down_o, right_o, left_o;
    logic ce_i = 1'b0, cfg_shift_i = 1'b0, cfg_din_i = 1'b0, cfg_commit_i = 1'b0;
    logic cfg_so_o, cfg_full_o, cfg_valid_o, cfg_err_o;

    int total = 0;
    int bad   = 0;

    // Reference state: shadow as a queue (index 0 = oldest bit, the one at cfg_so_o).
    bit            m_sh[$];
    bit [CFGB-1:0] m_act;
    bit            m_q[2];
    int            m_cnt;
    bit            m_run, m_valid, m_err;

    clb_param #(.W(1), .K(4), .NB(2)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .up_i(up_i), .down_i(down_i), .right_i(right_i), .left_i(left_i),
        .up_o(up_o), .down_o(down_o), .right_o(right_o), .left_o(left_o),
        .ce_i(ce_i), .cfg_shift_i(cfg_shift_i), .cfg_din_i(cfg_din_i),
        .cfg_commit_i(cfg_commit_i), .cfg_so_o(cfg_so_o), .cfg_full_o(cfg_full_o),
        .cfg_valid_o(cfg_valid_o), .cfg_err_o(cfg_err_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic int get(bit [CFGB-1:0] v, int lo, int n);
        int r = 0;
        for (int i = 0; i < n; i++) if (v[lo+i]) r += (1 << i);
        return r;
    endfunction

    function automatic bit [CFGB-1:0] put(bit [CFGB-1:0] v, int lo, int n, int val);
        for (int i = 0; i < n; i++) v[lo+i] = val[i];
        return v;
    endfunction

    function automatic bit pool_val(int idx);
        case (idx)
            0: return bit'(up_i);
            1: return bit'(down_i);
            2: return bit'(right_i);
            3: return bit'(left_i);
            4: return m_q[0];
            5: return m_q[1];
            default: return 1'b0;
        endcase
    endfunction

    function automatic bit lut_out(int b);
        int base = b * BLEW;
        int addr = 0;
        for (int i = 0; i < K; i++)
            if (pool_val(get(m_act, base + 16 + i*SELW, SELW))) addr += (1 << i);
        return m_act[base + addr];
    endfunction

    function automatic bit exp_side(int s);
        int sel;
        if (!m_run) return 1'b0;
        sel = get(m_act, OSB + 2*s, 2);
        if (sel == 0) return pool_val(s ^ 1);
        if (sel <= NB) return m_act[(sel-1)*BLEW + 28] ? m_q[sel-1] : lut_out(sel-1);
        return 1'b0;
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(string tag);
        chk({tag, ".up"},    up_o,        exp_side(0));
        chk({tag, ".down"},  down_o,      exp_side(1));
        chk({tag, ".right"}, right_o,     exp_side(2));
        chk({tag, ".left"},  left_o,      exp_side(3));
        chk({tag, ".so"},    cfg_so_o,    m_sh[0]);
        chk({tag, ".full"},  cfg_full_o,  m_cnt == CFGB);
        chk({tag, ".valid"}, cfg_valid_o, m_valid);
        chk({tag, ".err"},   cfg_err_o,   m_err);
    endtask

    // Advance one clock: model next state from pre-edge inputs, then let the DUT take the edge.
    task automatic tick();
        bit            n_q[2];
        bit [CFGB-1:0] n_act;
        bit            n_sh[$];
        int            n_cnt;
        bit            n_run, n_valid, n_err, full, good;
        n_q = m_q; n_act = m_act; n_sh = m_sh; n_cnt = m_cnt;
        n_run = m_run; n_valid = m_valid; n_err = 1'b0;
        full = (m_cnt == CFGB);
        good = cfg_commit_i && full;
        if (rst_i) begin
            n_q = '{1'b0, 1'b0}; n_act = '0; n_cnt = 0; n_run = 0; n_valid = 0;
            n_sh.delete();
            for (int i = 0; i < CFGB; i++) n_sh.push_back(1'b0);
        end else if (cfg_commit_i) begin
            if (full) begin
                for (int i = 0; i < CFGB; i++) n_act[i] = m_sh[i];
                for (int b = 0; b < NB; b++) n_q[b] = m_sh[b*BLEW + 29];
                n_cnt = 0; n_valid = 1; n_run = 1;
            end else begin
                n_err = 1'b1;
            end
        end else if (cfg_shift_i) begin
            n_sh.push_back(bit'(cfg_din_i));
            void'(n_sh.pop_front());
            if (n_cnt < CFGB) n_cnt++;
        end
        if (!rst_i && !good && m_run && ce_i)
            for (int b = 0; b < NB; b++) n_q[b] = lut_out(b);
        @(posedge clk_i);
        #1;
        m_q = n_q; m_act = n_act; m_sh = n_sh; m_cnt = n_cnt;
        m_run = n_run; m_valid = n_valid; m_err = n_err;
    endtask

    task automatic set_in(bit [3:0] v);
        {up_i, down_i, right_i, left_i} = v;
        #1;
    endtask

    task automatic load_cfg(bit [CFGB-1:0] c);
        for (int j = 0; j < CFGB; j++) begin
            cfg_shift_i = 1'b1; cfg_din_i = c[j];
            tick();
        end
        cfg_shift_i = 1'b0;
    endtask

    task automatic commit();
        cfg_commit_i = 1'b1;
        tick();
        cfg_commit_i = 1'b0;
        #1;
    endtask

    initial begin
        bit [CFGB-1:0] c;
        bit [69:0]     c70;

        for (int i = 0; i < CFGB; i++) m_sh.push_back(1'b0);
        m_act = '0; m_q = '{1'b0, 1'b0}; m_cnt = 0; m_run = 0; m_valid = 0; m_err = 0;

        tick(); tick();
        rst_i = 1'b0; #1;
        chk_all("reset");

        // Unconfigured: everything forced low; short commit is an error.
        for (int i = 0; i < 4; i++) begin
            set_in(4'($urandom));
            chk_all("uncfg");
            tick();
        end
        for (int j = 0; j < 10; j++) begin
            cfg_shift_i = 1'b1; cfg_din_i = 1'($urandom); tick();
        end
        cfg_shift_i = 1'b0;
        commit();
        chk("err_pulse", cfg_err_o, 1);
        chk("err_valid", cfg_valid_o, 0);
        chk_all("err");
        tick();
        chk("err_once", cfg_err_o, 0);

        // All-zero config: pure pass-through.
        load_cfg('0);
        chk("full68", cfg_full_o, 1);
        commit();
        chk("valid0", cfg_valid_o, 1);
        set_in(4'b1101);
        chk("pass_down", down_o, 1);
        chk("pass_up", up_o, 1);
        chk("pass_left", left_o, 0);
        chk("pass_right", right_o, 1);
        chk_all("pass");

        // AND4 on BLE0 combinational to down_o.
        c = '0;
        c = put(c, 0, 16, 'h8000);
        for (int i = 0; i < 4; i++) c = put(c, 16 + 3*i, 3, i);
        c = put(c, OSB + 2, 2, 1);
        load_cfg(c);
        commit();
        set_in(4'b1111);
        chk("and_1111", down_o, 1);
        chk_all("and_a");
        set_in(4'b1101);
        chk("and_1101", down_o, 0);
        chk("and_up_pass", up_o, 1);
        chk_all("and_b");

        // Same LUT through the flop.
        c = put(c, 28, 1, 1);
        load_cfg(c);
        commit();
        ce_i = 1'b1;
        set_in(4'b1111);
        chk("ff_before", down_o, 0);
        tick();
        chk("ff_after", down_o, 1);
        ce_i = 1'b0;
        set_in(4'b0000);
        tick();
        chk("ff_hold", down_o, 1);
        chk_all("ff");

        // BLE1 toggles on its own q.
        c = '0;
        c = put(c, BLEW, 16, 'h5555);
        c = put(c, BLEW + 16, 3, 5);
        c = put(c, BLEW + 28, 2, 3);
        c = put(c, OSB + 4, 2, 2);
        load_cfg(c);
        commit();
        chk("tog_init", right_o, 1);
        ce_i = 1'b1;
        tick();
        chk("tog_1", right_o, 0);
        tick();
        chk("tog_2", right_o, 1);
        chk_all("tog");
        ce_i = 1'b0;

        // Commit wins over a same-cycle shift.
        load_cfg(c);
        cfg_shift_i = 1'b1; cfg_din_i = 1'b1;
        commit();
        cfg_shift_i = 1'b0; #1;
        chk("cws_full", cfg_full_o, 0);
        chk_all("cws");
        for (int j = 0; j < CFGB - 1; j++) begin
            cfg_shift_i = 1'b1; cfg_din_i = 1'($urandom); tick();
        end
        chk("cws_67", cfg_full_o, 0);
        tick();
        cfg_shift_i = 1'b0;
        chk("cws_68", cfg_full_o, 1);

        // Overshift by two: the first two bits appear on cfg_so_o.
        c70 = {$urandom, $urandom, $urandom};
        for (int j = 0; j < 70; j++) begin
            cfg_shift_i = 1'b1; cfg_din_i = c70[j]; tick();
            if (j == 67) chk("so_bit0", cfg_so_o, c70[0]);
            if (j == 68) chk("so_bit1", cfg_so_o, c70[1]);
        end
        cfg_shift_i = 1'b0;
        chk("so_full", cfg_full_o, 1);
        chk_all("so");

        // Reset while running.
        commit();
        set_in(4'b1111);
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0; #1;
        chk("rst_out", {up_o, down_o, right_o, left_o}, 0);
        chk("rst_valid", cfg_valid_o, 0);
        chk_all("rst");

        // Random configs followed by random traffic.
        for (int it = 0; it < 10; it++) begin
            c = {$urandom, $urandom, $urandom};
            ce_i = 1'($urandom);
            load_cfg(c);
            commit();
            chk_all("rnd_commit");
            for (int n = 0; n < 60; n++) begin
                set_in(4'($urandom));
                ce_i         = 1'($urandom);
                cfg_shift_i  = 1'($urandom);
                cfg_din_i    = 1'($urandom);
                cfg_commit_i = ($urandom_range(0, 19) == 0);
                rst_i        = ($urandom_range(0, 149) == 0);
                #1;
                chk_all("rnd");
                tick();
            end
            cfg_shift_i = 1'b0; cfg_commit_i = 1'b0; rst_i = 1'b0; #1;
            chk_all("rnd_end");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
